// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing with a valid/ready output register.
// Latency: the word appears one clk after the stop-bit sample tick (2-flop input synchronizer ahead of the FSM).
// Backpressure: the word is held in rx_data until it is accepted; a new good frame arriving while a word is pending is dropped and flagged with overrun_err.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   rx_tick             oversample enable, one pulse per 1/OVERSAMPLE_RATE bit period
//   rx_serial           asynchronous serial line, idles high
//   rx_ready            consumer accepts rx_data when high together with rx_valid
//   rx_data/rx_valid    received word (LSB = first bit on the line) and its pending flag
//   rx_busy             FSM not in IDLE
//   frame_err           one-cycle pulse: stop bit sampled low
//   overrun_err         one-cycle pulse: good frame dropped because rx_valid was pending
module uart_rx #(
    parameter int DATA_BITS       = 8,
    parameter int OVERSAMPLE_RATE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rx_serial,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE_RATE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    // Start bit is checked at mid-bit; every later sample is one full bit period on.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE_RATE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE_RATE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic                 sync1_q, sync2_q;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 busy_q;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 stop_good, stop_bad;
    logic                 line;

    assign line = sync2_q;

    // Framing FSM; only moves on oversample ticks.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        if (rx_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!line) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        if (line) begin
                            state_d = S_IDLE;       // glitch, not a start bit
                        end else begin
                            state_d = S_DATA;
                            cnt_d   = '0;
                            idx_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d   = '0;
                        // Shift right so the first bit ends up in the LSB.
                        shift_d = {line, shift_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d = '0;
                        if (line) begin
                            stop_good = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            stop_bad  = 1'b1;
                            state_d   = S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A broken frame's low line must not look like a new start bit.
                    if (line) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output register and handshake; evaluated every clk.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        ferr_d  = stop_bad;
        if (stop_good && (!valid_q || rx_ready)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (stop_good) begin
            ovr_d   = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= rx_serial;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != S_IDLE);
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign rx_busy     = busy_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at OVERSAMPLE_RATE=8, one at 16.
// Tick every 4th clk for the directed frames, every clk for the 256-value sweeps.
// Frame timing is derived from the edge at which the start bit is driven.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_tick = 1'b0;
    logic       ser8 = 1'b1, ser16 = 1'b1;
    logic       rdy8 = 1'b0, rdy16 = 1'b0;
    logic [7:0] data8, data16;
    logic       val8, busy8, fe8, ov8;
    logic       val16, busy16, fe16, ov16;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tdiv  = 4;
    int tcnt  = 0;
    int fe8_cnt = 0, ov8_cnt = 0, fe16_cnt = 0, ov16_cnt = 0, both_cnt = 0;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE_RATE(8)) dut (
        .clk(clk), .reset(reset), .rx_tick(rx_tick), .rx_serial(ser8), .rx_ready(rdy8),
        .rx_data(data8), .rx_valid(val8), .rx_busy(busy8), .frame_err(fe8), .overrun_err(ov8)
    );

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE_RATE(16)) dut16 (
        .clk(clk), .reset(reset), .rx_tick(rx_tick), .rx_serial(ser16), .rx_ready(rdy16),
        .rx_data(data16), .rx_valid(val16), .rx_busy(busy16), .frame_err(fe16), .overrun_err(ov16)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Tick generator: rx_tick high during the cycle before every tdiv-th edge.
    always @(posedge clk) begin
        #1;
        if (tcnt + 1 >= tdiv) tcnt = 0;
        else tcnt = tcnt + 1;
        rx_tick = (tcnt == 0);
    end

    always @(posedge clk) begin
        if (fe8)        fe8_cnt  <= fe8_cnt + 1;
        if (ov8)        ov8_cnt  <= ov8_cnt + 1;
        if (fe16)       fe16_cnt <= fe16_cnt + 1;
        if (ov16)       ov16_cnt <= ov16_cnt + 1;
        if ((fe8 && ov8) || (fe16 && ov16)) both_cnt <= both_cnt + 1;
    end

    initial begin
        #990000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Return on the falling edge after rising edge number tgt.
    task automatic wait_edge(input int tgt);
        while (cyc < tgt) @(negedge clk);
    endtask

    // Stop just after edge n where the next edge (n+1) is a tick edge.
    task automatic align(output int n);
        @(posedge clk); #2;
        while (!rx_tick) begin
            @(posedge clk); #2;
        end
        n = cyc;
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic stop, input int per);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            if (sel) ser16 = bits[k];
            else     ser8  = bits[k];
            repeat (per) @(posedge clk);
            #2;
        end
        if (sel) ser16 = 1'b1;
        else     ser8  = 1'b1;
    endtask

    task automatic ack(input bit sel);
        @(negedge clk);
        if (sel) rdy16 = 1'b1;
        else     rdy8  = 1'b1;
        @(negedge clk);
        rdy8  = 1'b0;
        rdy16 = 1'b0;
    endtask

    initial begin
        int n, n2, fe0, ov0, f16, o16;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data",  32'(data8), 0);
        check("rst_valid", 32'(val8),  0);
        check("rst_busy",  32'(busy8), 0);
        check("rst_ferr",  32'(fe8),   0);
        check("rst_ovr",   32'(ov8),   0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Good frame 0xA5: T0 = n+5, stop sample at n+5+4*(4+72) = n+309
        align(n);
        fork
            send(1'b0, 8'hA5, 1'b1, 32);
            begin
                wait_edge(n + 308);
                check("a5_valid_early", 32'(val8), 0);
                wait_edge(n + 309);
                check("a5_valid", 32'(val8), 1);
                check("a5_data",  32'(data8), 32'hA5);
            end
        join
        repeat (20) @(negedge clk);
        check("a5_hold_valid", 32'(val8), 1);
        check("a5_hold_data",  32'(data8), 32'hA5);
        ack(1'b0);
        check("a5_ack_valid", 32'(val8), 0);
        check("a5_ack_data",  32'(data8), 32'hA5);

        // False start: low for 2 ticks; sample at T0+4 ticks = n+21 sees high
        fe0 = fe8_cnt;
        align(n);
        ser8 = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        ser8 = 1'b1;
        wait_edge(n + 20);
        check("fs_busy_in_start", 32'(busy8), 1);
        wait_edge(n + 21);
        check("fs_busy_back_idle", 32'(busy8), 0);
        repeat (40) @(negedge clk);
        check("fs_valid", 32'(val8), 0);
        check("fs_busy",  32'(busy8), 0);
        check("fs_ferr_count", 32'(fe8_cnt - fe0), 0);

        // Framing error 0x3C, line low for 20 ticks from the stop bit
        fe0 = fe8_cnt;
        align(n);
        fork
            begin
                send(1'b0, 8'h3C, 1'b0, 32);
                ser8 = 1'b0;
                repeat (48) @(posedge clk);
                #2;
                ser8 = 1'b1;
            end
            begin
                wait_edge(n + 308);
                check("fe_before", 32'(fe8), 0);
                wait_edge(n + 309);
                check("fe_pulse", 32'(fe8), 1);
                wait_edge(n + 310);
                check("fe_after", 32'(fe8), 0);
                wait_edge(n + 360);
                check("fe_busy_wait_high", 32'(busy8), 1);
                check("fe_valid", 32'(val8), 0);
            end
        join
        // Line high at edge n+368 -> synced at n+370 -> next tick edge n+373
        wait_edge(n + 372);
        check("fe_busy_until_high", 32'(busy8), 1);
        wait_edge(n + 373);
        check("fe_busy_released", 32'(busy8), 0);
        check("fe_count", 32'(fe8_cnt - fe0), 1);
        check("fe_valid_after", 32'(val8), 0);

        align(n);
        send(1'b0, 8'h5A, 1'b1, 32);
        @(negedge clk);
        check("5a_valid", 32'(val8), 1);
        check("5a_data",  32'(data8), 32'h5A);
        ack(1'b0);

        // Overrun: 0x11 then 0x22 back to back, rx_ready low
        ov0 = ov8_cnt;
        align(n);
        send(1'b0, 8'h11, 1'b1, 32);
        n2 = n + 320;
        fork
            send(1'b0, 8'h22, 1'b1, 32);
            begin
                wait_edge(n2 + 308);
                check("ov_before", 32'(ov8), 0);
                wait_edge(n2 + 309);
                check("ov_pulse", 32'(ov8), 1);
                check("ov_data",  32'(data8), 32'h11);
                wait_edge(n2 + 310);
                check("ov_after", 32'(ov8), 0);
            end
        join
        @(negedge clk);
        check("ov_count", 32'(ov8_cnt - ov0), 1);
        check("ov_valid", 32'(val8), 1);
        check("ov_data_kept", 32'(data8), 32'h11);
        ack(1'b0);

        // Overrun repeat with rx_ready high exactly in the load cycle
        ov0 = ov8_cnt;
        align(n);
        send(1'b0, 8'h11, 1'b1, 32);
        n2 = n + 320;
        fork
            send(1'b0, 8'h22, 1'b1, 32);
            begin
                wait_edge(n2 + 308);
                check("sim_pending", 32'(val8), 1);
                rdy8 = 1'b1;
                wait_edge(n2 + 309);
                rdy8 = 1'b0;
                check("sim_data",  32'(data8), 32'h22);
                check("sim_valid", 32'(val8), 1);
                check("sim_no_ovr", 32'(ov8), 0);
            end
        join
        check("sim_ov_count", 32'(ov8_cnt - ov0), 0);
        ack(1'b0);
        check("sim_ack_valid", 32'(val8), 0);

        // Reset during data bit 3 of 0xFF (bit 3 sample would be at n+149)
        fe0 = fe8_cnt;
        align(n);
        fork
            send(1'b0, 8'hFF, 1'b1, 32);
            begin
                wait_edge(n + 139);
                reset = 1'b1;
                wait_edge(n + 140);
                reset = 1'b0;
                check("mr_data",  32'(data8), 0);
                check("mr_valid", 32'(val8),  0);
                check("mr_busy",  32'(busy8), 0);
                check("mr_ferr",  32'(fe8),   0);
                check("mr_ovr",   32'(ov8),   0);
            end
        join
        repeat (20) @(negedge clk);
        check("mr_no_valid", 32'(val8), 0);
        check("mr_no_busy",  32'(busy8), 0);
        check("mr_no_ferr",  32'(fe8_cnt - fe0), 0);
        align(n);
        send(1'b0, 8'h81, 1'b1, 32);
        @(negedge clk);
        check("81_valid", 32'(val8), 1);
        check("81_data",  32'(data8), 32'h81);
        ack(1'b0);

        // Sweeps: tick every clk, OVERSAMPLE_RATE 8 then 16
        tdiv = 1;
        fe0 = fe8_cnt; ov0 = ov8_cnt; f16 = fe16_cnt; o16 = ov16_cnt;
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 256; v++) begin
                logic [7:0] d;
                d = 8'(v);
                align(n);
                send(s[0], d, 1'b1, (s == 0) ? 8 : 16);
                @(negedge clk);
                check((s == 0) ? "sw8_valid" : "sw16_valid", 32'((s == 0) ? val8 : val16), 1);
                check((s == 0) ? "sw8_data" : "sw16_data", 32'((s == 0) ? data8 : data16), 32'(d));
                ack(s[0]);
                check((s == 0) ? "sw8_ack" : "sw16_ack", 32'((s == 0) ? val8 : val16), 0);
            end
        end
        check("sw8_ferr",  32'(fe8_cnt - fe0),  0);
        check("sw8_ovr",   32'(ov8_cnt - ov0),  0);
        check("sw16_ferr", 32'(fe16_cnt - f16), 0);
        check("sw16_ovr",  32'(ov16_cnt - o16), 0);
        check("sw16_busy", 32'(busy16), 0);
        check("err_overlap", 32'(both_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE_RATE, default 8, rx_tick pulses per bit period; must be even and at least 4.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 rx_tick  input  1  oversample enable from the baud generator; one-cycle pulse at BAUD_RATE*OVERSAMPLE_RATE.
REQ-006 rx_serial  input  1  asynchronous serial line; idles high.
REQ-007 rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
REQ-008 rx_data  output  DATA_BITS  last good received word, LSB = first bit received.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 rx_busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-012 overrun_err  output  1  one-cycle pulse when a good frame is dropped because rx_valid is still pending.

Function
REQ-013 rx_serial shall pass through a 2-flop synchronizer (both flops reset to 1) before use; all FSM decisions use the synchronized value.
REQ-014 The FSM and the tick counter shall advance only in cycles where rx_tick=1; handshake logic runs every cycle.
REQ-015 States: IDLE, START, DATA, STOP, WAIT_HIGH; the FSM shall use a tick counter of width clog2(OVERSAMPLE_RATE) and a bit index of width clog2(DATA_BITS+1).
REQ-016 IDLE: on a tick with synced line = 0 (tick T0), go to START with tick counter = 0.
REQ-017 START: on each tick, increment the counter; on tick T0+OVERSAMPLE_RATE/2, sample the line.
- Line = 1: false start; go to IDLE.
- Line = 0: clear the counter and bit index, then go to DATA.
REQ-018 DATA: sample bit i on tick T0+OVERSAMPLE_RATE/2+(i+1)*OVERSAMPLE_RATE, shifting LSB-first into a shift register; after bit DATA_BITS-1, go to STOP with the counter cleared.
REQ-019 STOP: sample on tick T0+OVERSAMPLE_RATE/2+(DATA_BITS+1)*OVERSAMPLE_RATE.
- Line = 1: good frame; go to IDLE.
- Line = 0: pulse frame_err, discard the word, and go to WAIT_HIGH.
REQ-020 WAIT_HIGH: go to IDLE on the first tick with synced line = 1; no start detection shall occur in this state.
REQ-021 Good frame with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle: load rx_data and set rx_valid=1 in the cycle after the stop-sample tick.
REQ-022 Good frame with rx_valid=1 and rx_ready=0: rx_data and rx_valid are unchanged, and overrun_err pulses in the cycle after the stop-sample tick.
REQ-023 rx_valid=1 and rx_ready=1 with no simultaneous load: rx_valid clears next cycle; rx_data holds its value.
REQ-024 rx_valid shall stay high until accepted; rx_data shall not change while rx_valid=1 except by the simultaneous-accept load of REQ-021.
REQ-025 frame_err and overrun_err shall each be high for exactly one clk cycle per event and shall never be high in the same cycle.
REQ-026 rx_busy = (state != IDLE), registered with the state.

Reset
REQ-027 reset=1, including mid-frame, shall force the following on the next edge:
- state = IDLE; counter, bit index and shift register = 0.
- Synchronizer flops = 1.
- rx_data = 0; rx_valid = rx_busy = frame_err = overrun_err = 0.
REQ-028 reset shall override rx_tick, rx_serial and rx_ready in the same cycle.
REQ-029 The first start detection after reset shall need two synced-low samples through the synchronizer; no frame is inferred from pre-reset state.

Verification (DATA_BITS=8, OVERSAMPLE_RATE=8, rx_tick every 4th clk)
REQ-030 Good frame:
- Stimulus: 0xA5, bits 1,0,1,0,0,1,0,1 LSB first, stop=1, rx_ready=0.
- Response: rx_data=0xA5 and rx_valid=1 one cycle after the stop-sample tick; they hold until rx_ready=1, then rx_valid=0 the next cycle.
REQ-031 False start:
- Stimulus: line low for 2 ticks, then high.
- Response: START returns to IDLE at T0+4; rx_valid, frame_err and rx_busy are 0 after that.
REQ-032 Framing error:
- Stimulus: 0x3C with stop=0, line held low 20 ticks, then high.
- Response: frame_err is a single-cycle pulse; rx_valid stays 0; rx_busy stays 1 until the first high tick; the next frame 0x5A is received correctly.
REQ-033 Overrun:
- Stimulus: back-to-back 0x11 then 0x22, rx_ready=0 throughout.
- Response: rx_data=0x11; overrun_err pulses once at the 0x22 stop sample.
- Repeat with rx_ready=1 exactly in the load cycle: rx_data=0x22, rx_valid stays 1, no overrun.
REQ-034 Reset mid-frame:
- Stimulus: assert reset for 1 cycle during data bit 3 of 0xFF.
- Response: all outputs 0 and state IDLE next cycle; the remaining bits of 0xFF produce no rx_valid; a subsequent 0x81 is received correctly.
REQ-035 Sweep: all 256 values at OVERSAMPLE_RATE=8 and 16 shall produce matching rx_data, with zero frame_err and zero overrun_err.
